// File: rtl/instr_exec_unit.sv
// Instruction execution unit: fetches a burst of instruction words by read_pointer,
// executes each one and returns the results one at a time over a valid/ready handshake.
module instr_exec_unit #(
    parameter int OP_W = 32,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [AW-1:0]         start_ptr,
    input  logic [AW:0]           count,
    output logic [AW-1:0]         read_pointer,
    input  logic [3+2*OP_W-1:0]   instruction_word,
    output logic [2*OP_W-1:0]     result,
    output logic [AW-1:0]         res_addr,
    output logic                  res_err,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = 3 + 2 * OP_W;
    localparam int RW = 2 * OP_W;
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   REM_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   REM_ZERO = {(AW+1){1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_RESP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [AW-1:0]       r_ptr;
    logic [AW:0]         r_remaining;
    logic [IW-1:0]       r_instr;
    logic [AW-1:0]       r_read_pointer;
    logic [RW-1:0]       r_result;
    logic [AW-1:0]       r_res_addr;
    logic                r_res_err;
    logic                r_res_valid;
    logic                r_busy;
    logic                r_done;
    logic                w_accept;
    logic [RW:0]         w_exec;

    // Returns {err, result}: operands are sign-extended so no operation can overflow.
    function automatic logic [RW:0] exec_op(input logic [IW-1:0] word);
        logic [2:0]           opc;
        logic signed [RW-1:0] a;
        logic signed [RW-1:0] b;
        logic signed [RW-1:0] r;
        logic                 err;
        opc = word[IW-1 -: 3];
        a   = {{OP_W{word[2*OP_W-1]}}, word[2*OP_W-1:OP_W]};
        b   = {{OP_W{word[OP_W-1]}}, word[OP_W-1:0]};
        r   = {RW{1'b0}};
        err = 1'b0;
        case (opc)
            3'd0: r = {RW{1'b0}};
            3'd1: r = a;
            3'd2: r = b;
            3'd3: r = a + b;
            3'd4: r = a - b;
            3'd5: r = a * b;
            3'd6: begin
                if (b == {RW{1'b0}}) err = 1'b1;
                else                 r = a / b;
            end
            3'd7: begin
                if (b == {RW{1'b0}}) err = 1'b1;
                else                 r = a % b;
            end
            default: r = {RW{1'b0}};
        endcase
        return {err, r};
    endfunction

    assign w_exec   = exec_op(r_instr);
    assign w_accept = r_res_valid && res_ready;

    assign read_pointer = r_read_pointer;
    assign result       = r_result;
    assign res_addr     = r_res_addr;
    assign res_err      = r_res_err;
    assign res_valid    = r_res_valid;
    assign busy         = r_busy;
    assign done         = r_done;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (count != REM_ZERO) w_next_state = S_FETCH;
                    else                   w_next_state = S_DONE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FETCH: w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP: begin
                if (w_accept) begin
                    if (r_remaining == REM_ONE) w_next_state = S_DONE;
                    else                        w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; a reset discards any pending result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr          <= {AW{1'b0}};
            r_remaining    <= REM_ZERO;
            r_instr        <= {IW{1'b0}};
            r_read_pointer <= {AW{1'b0}};
            r_result       <= {RW{1'b0}};
            r_res_addr     <= {AW{1'b0}};
            r_res_err      <= 1'b0;
            r_res_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_next_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start && (count != REM_ZERO)) begin
                        r_ptr          <= start_ptr;
                        r_remaining    <= count;
                        r_read_pointer <= start_ptr;
                    end
                end
                S_FETCH: begin
                    r_instr    <= instruction_word;
                    r_res_addr <= r_ptr;
                end
                S_EXEC: begin
                    r_res_err   <= w_exec[RW];
                    r_result    <= w_exec[RW-1:0];
                    r_res_valid <= 1'b1;
                end
                S_RESP: begin
                    if (w_accept) begin
                        r_res_valid <= 1'b0;
                        r_remaining <= r_remaining - REM_ONE;
                        r_ptr       <= r_ptr + PTR_ONE;
                        if (r_remaining != REM_ONE) r_read_pointer <= r_ptr + PTR_ONE;
                    end
                end
                S_DONE:  r_done <= 1'b1;
                default: r_done <= 1'b0;
            endcase
        end
    end

endmodule
